// File: rtl/llr_retry_seq_ctrl.sv
// Link-layer retry sequencer: NORMAL/LLRREQ/LOCAL_IDLE/PHY_REINIT/PHY_WAIT/ABORT with retry/reinit counters.
// One-cycle registered response; RETRY.Req held until i_req_sent, PHY reinit request held until PHY reports reinit.
module llr_retry_seq_ctrl #(
    parameter int RETRY_W = 5,
    parameter int TO_W    = 13
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pl_lnk_up,
    input  logic [3:0]         i_pl_state_sts,
    input  logic               i_rx_crc_err,
    input  logic               i_rx_retry_ack,
    input  logic               i_req_sent,
    input  logic               i_flit_tick,
    input  logic [RETRY_W-1:0] i_retry_threshold,
    input  logic [RETRY_W-1:0] i_reinit_threshold,
    input  logic [TO_W-1:0]    i_timeout_max,
    input  logic               i_sts_clr,
    output logic               o_send_req_seq,
    output logic               o_phy_reinit_req,
    output logic               o_discard_rx,
    output logic               o_link_failure,
    output logic               o_retry_threshold_hit,
    output logic               o_reinit_threshold_hit,
    output logic [RETRY_W-1:0] o_num_retry,
    output logic [RETRY_W-1:0] o_num_phy_reinit,
    output logic [2:0]         o_state
);

    localparam logic [2:0] ST_NORMAL     = 3'd0;
    localparam logic [2:0] ST_LLRREQ     = 3'd1;
    localparam logic [2:0] ST_LOCAL_IDLE = 3'd2;
    localparam logic [2:0] ST_PHY_REINIT = 3'd3;
    localparam logic [2:0] ST_PHY_WAIT   = 3'd4;
    localparam logic [2:0] ST_ABORT      = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [RETRY_W-1:0] num_retry_q, num_retry_d;
    logic [RETRY_W-1:0] num_reinit_q, num_reinit_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               send_req_q, send_req_d;
    logic               reinit_req_q, reinit_req_d;
    logic               retry_hit_q, retry_hit_d;
    logic               reinit_hit_q, reinit_hit_d;
    logic               retry_hit_set, reinit_hit_set;
    logic               retry_sat, reinit_sat, to_sat, timeout_hit;

    assign retry_sat   = &num_retry_q;
    assign reinit_sat  = &num_reinit_q;
    assign to_sat      = &to_cnt_q;
    assign timeout_hit = (i_timeout_max != '0) && i_flit_tick &&
                         (to_cnt_q == i_timeout_max - TO_W'(1));

    always_comb begin
        state_d        = state_q;
        num_retry_d    = num_retry_q;
        num_reinit_d   = num_reinit_q;
        to_cnt_d       = to_cnt_q;
        retry_hit_set  = 1'b0;
        reinit_hit_set = 1'b0;

        if (state_q == ST_LOCAL_IDLE && i_flit_tick && !to_sat)
            to_cnt_d = to_cnt_q + TO_W'(1);

        case (state_q)
            ST_NORMAL: begin
                if (!i_pl_lnk_up)
                    state_d = ST_PHY_REINIT;
                else if (i_rx_crc_err)
                    state_d = ST_LLRREQ;
            end
            ST_LLRREQ: begin
                if (!i_pl_lnk_up) begin
                    state_d = ST_PHY_REINIT;
                end else if (num_retry_q >= i_retry_threshold) begin
                    state_d       = ST_PHY_REINIT;
                    retry_hit_set = 1'b1;
                end else if (send_req_q && i_req_sent) begin
                    num_retry_d = retry_sat ? num_retry_q : num_retry_q + RETRY_W'(1);
                    to_cnt_d    = '0;
                    state_d     = ST_LOCAL_IDLE;
                end
            end
            ST_LOCAL_IDLE: begin
                // Ack outranks a same-cycle timeout; link loss outranks both.
                if (!i_pl_lnk_up) begin
                    state_d = ST_PHY_REINIT;
                end else if (i_rx_retry_ack) begin
                    state_d      = ST_NORMAL;
                    num_retry_d  = '0;
                    num_reinit_d = '0;
                end else if (timeout_hit) begin
                    state_d = ST_LLRREQ;
                end
            end
            ST_PHY_REINIT: begin
                if (num_reinit_q >= i_reinit_threshold) begin
                    state_d        = ST_ABORT;
                    reinit_hit_set = 1'b1;
                end else if (i_pl_state_sts == 4'h0) begin
                    state_d      = ST_PHY_WAIT;
                    num_reinit_d = reinit_sat ? num_reinit_q : num_reinit_q + RETRY_W'(1);
                    num_retry_d  = '0;
                end
            end
            ST_PHY_WAIT: begin
                if (i_pl_lnk_up && i_pl_state_sts == 4'hF)
                    state_d = ST_LLRREQ;
            end
            ST_ABORT: state_d = ST_ABORT;
            default:  state_d = ST_NORMAL;
        endcase

        // Request strobes are precomputed from next state so outputs stay register-driven.
        send_req_d   = (state_d == ST_LLRREQ) && (num_retry_d < i_retry_threshold);
        reinit_req_d = (state_d == ST_PHY_REINIT) && (num_reinit_d < i_reinit_threshold);
        retry_hit_d  = retry_hit_set  | (retry_hit_q  & ~i_sts_clr);
        reinit_hit_d = reinit_hit_set | (reinit_hit_q & ~i_sts_clr);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_NORMAL;
            num_retry_q  <= '0;
            num_reinit_q <= '0;
            to_cnt_q     <= '0;
            send_req_q   <= 1'b0;
            reinit_req_q <= 1'b0;
            retry_hit_q  <= 1'b0;
            reinit_hit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_retry_q  <= num_retry_d;
            num_reinit_q <= num_reinit_d;
            to_cnt_q     <= to_cnt_d;
            send_req_q   <= send_req_d;
            reinit_req_q <= reinit_req_d;
            retry_hit_q  <= retry_hit_d;
            reinit_hit_q <= reinit_hit_d;
        end
    end

    assign o_send_req_seq         = send_req_q;
    assign o_phy_reinit_req       = reinit_req_q;
    assign o_discard_rx           = (state_q != ST_NORMAL);
    assign o_link_failure         = (state_q == ST_ABORT);
    assign o_retry_threshold_hit  = retry_hit_q;
    assign o_reinit_threshold_hit = reinit_hit_q;
    assign o_num_retry            = num_retry_q;
    assign o_num_phy_reinit       = num_reinit_q;
    assign o_state                = state_q;

endmodule

// File: tb/tb_llr_retry_seq_ctrl.sv
// Bench for llr_retry_seq_ctrl: directed scenarios with literal expectations, then random traffic vs a reference model.
module tb_llr_retry_seq_ctrl;
    localparam int RW = 5;
    localparam int TW = 13;

    logic          clk = 1'b0;
    logic          rst, lnk, crc, ack, sent, ftick, clr;
    logic [3:0]    sts;
    logic [RW-1:0] rthr, pthr;
    logic [TW-1:0] tmax;
    logic          send, preq, disc, lfail, rhit, phit;
    logic [RW-1:0] nr, np;
    logic [2:0]    st;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 NORMAL,1 LLRREQ,2 LOCAL_IDLE,3 PHY_REINIT,4 PHY_WAIT,5 ABORT
    int m_state, m_nr, m_np, m_to;
    bit m_send, m_preq, m_rhit, m_phit;

    llr_retry_seq_ctrl #(.RETRY_W(RW), .TO_W(TW)) dut (
        .i_clk(clk), .i_rst(rst), .i_pl_lnk_up(lnk), .i_pl_state_sts(sts),
        .i_rx_crc_err(crc), .i_rx_retry_ack(ack), .i_req_sent(sent), .i_flit_tick(ftick),
        .i_retry_threshold(rthr), .i_reinit_threshold(pthr), .i_timeout_max(tmax),
        .i_sts_clr(clr), .o_send_req_seq(send), .o_phy_reinit_req(preq),
        .o_discard_rx(disc), .o_link_failure(lfail), .o_retry_threshold_hit(rhit),
        .o_reinit_threshold_hit(phit), .o_num_retry(nr), .o_num_phy_reinit(np), .o_state(st)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_nr = 0; m_np = 0; m_to = 0;
        m_send = 0; m_preq = 0; m_rhit = 0; m_phit = 0;
    endtask

    task automatic model_step();
        int  nxt = m_state;
        int  to_old = m_to;
        bit  rset = 0, pset = 0;
        int  cmax = (1 << RW) - 1;
        if (m_state == 2 && ftick && m_to < (1 << TW) - 1) m_to++;
        if (m_state <= 2 && !lnk) begin
            nxt = 3;
        end else if (m_state == 0) begin
            if (crc) nxt = 1;
        end else if (m_state == 1) begin
            if (m_nr >= int'(rthr)) begin nxt = 3; rset = 1; end
            else if (m_send && sent) begin
                m_nr = (m_nr < cmax) ? m_nr + 1 : m_nr; m_to = 0; nxt = 2;
            end
        end else if (m_state == 2) begin
            if (ack) begin nxt = 0; m_nr = 0; m_np = 0; end
            else if (tmax != 0 && ftick && to_old == int'(tmax) - 1) nxt = 1;
        end else if (m_state == 3) begin
            if (m_np >= int'(pthr)) begin nxt = 5; pset = 1; end
            else if (sts == 4'h0) begin
                nxt = 4; m_np = (m_np < cmax) ? m_np + 1 : m_np; m_nr = 0;
            end
        end else if (m_state == 4) begin
            if (lnk && sts == 4'hF) nxt = 1;
        end
        m_rhit  = rset ? 1'b1 : (clr ? 1'b0 : m_rhit);
        m_phit  = pset ? 1'b1 : (clr ? 1'b0 : m_phit);
        m_state = nxt;
        m_send  = (m_state == 1) && (m_nr < int'(rthr));
        m_preq  = (m_state == 3) && (m_np < int'(pthr));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        crc = 0; ack = 0; sent = 0; ftick = 0; clr = 0;
    endtask

    task automatic do_reset();
        #1 rst = 1;
        model_reset();
        #2 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; lnk = 1; sts = 4'hF; crc = 0; ack = 0; sent = 0; ftick = 0; clr = 0;
        rthr = 5'd3; pthr = 5'd3; tmax = 13'd8;
        model_reset();
        #12;
        checks++;
        if ({st, send, preq, disc, lfail, rhit, phit, nr, np} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {st, send, preq, disc, lfail, rhit, phit, nr, np});
        end
        rst = 0;
        step();
        checks++;
        if (st !== 3'd0 || disc !== 1'b0) begin
            errors++; $display("FAIL reset_idle state=%0d disc=%b want 0/0", st, disc);
        end
    endtask

    task automatic test_crc_recovery();
        rthr = 5'd3; tmax = 13'd8;
        crc = 1; step();
        checks++;
        if ({st, send, disc, nr} !== {3'd1, 1'b1, 1'b1, 5'd0}) begin
            errors++; $display("FAIL crc_enter state=%0d send=%b disc=%b nr=%0d want 1/1/1/0", st, send, disc, nr);
        end
        step();
        checks++;
        if (st !== 3'd1 || send !== 1'b1) begin
            errors++; $display("FAIL crc_hold state=%0d send=%b want 1/1", st, send);
        end
        sent = 1; step();
        checks++;
        if ({st, send, disc, nr} !== {3'd2, 1'b0, 1'b1, 5'd1}) begin
            errors++; $display("FAIL crc_sent state=%0d send=%b disc=%b nr=%0d want 2/0/1/1", st, send, disc, nr);
        end
        step(); step();
        checks++;
        if (st !== 3'd2 || disc !== 1'b1) begin
            errors++; $display("FAIL crc_idle state=%0d disc=%b want 2/1", st, disc);
        end
        ack = 1; step();
        checks++;
        if ({st, disc, nr} !== {3'd0, 1'b0, 5'd0}) begin
            errors++; $display("FAIL crc_ack state=%0d disc=%b nr=%0d want 0/0/0", st, disc, nr);
        end
    endtask

    task automatic test_timeout();
        rthr = 5'd3; tmax = 13'd4;
        crc = 1; step();
        sent = 1; step();
        for (int i = 0; i < 3; i++) begin ftick = 1; step(); end
        checks++;
        if (st !== 3'd2) begin errors++; $display("FAIL to_early state=%0d want 2", st); end
        ftick = 1; step();
        checks++;
        if (st !== 3'd1 || send !== 1'b1) begin
            errors++; $display("FAIL to_fire state=%0d send=%b want 1/1", st, send);
        end
        sent = 1; step();
        checks++;
        if (st !== 3'd2 || nr !== 5'd2) begin
            errors++; $display("FAIL to_second state=%0d nr=%0d want 2/2", st, nr);
        end
        for (int i = 0; i < 3; i++) begin ftick = 1; step(); end
        ftick = 1; ack = 1; step();
        checks++;
        if (st !== 3'd0 || nr !== 5'd0) begin
            errors++; $display("FAIL to_ack_prio state=%0d nr=%0d want 0/0", st, nr);
        end
    endtask

    task automatic test_retry_threshold();
        rthr = 5'd2; tmax = 13'd4; pthr = 5'd3;
        crc = 1; step();
        sent = 1; step();
        for (int i = 0; i < 4; i++) begin ftick = 1; step(); end
        sent = 1; step();
        checks++;
        if (nr !== 5'd2 || st !== 3'd2) begin
            errors++; $display("FAIL rt_count nr=%0d state=%0d want 2/2", nr, st);
        end
        for (int i = 0; i < 4; i++) begin ftick = 1; step(); end
        checks++;
        if (st !== 3'd1 || send !== 1'b0) begin
            errors++; $display("FAIL rt_at_thr state=%0d send=%b want 1/0", st, send);
        end
        step();
        checks++;
        if ({st, rhit, preq} !== {3'd3, 1'b1, 1'b1}) begin
            errors++; $display("FAIL rt_reinit state=%0d hit=%b preq=%b want 3/1/1", st, rhit, preq);
        end
        step();
        checks++;
        if (st !== 3'd3 || preq !== 1'b1) begin
            errors++; $display("FAIL rt_preq_hold state=%0d preq=%b want 3/1", st, preq);
        end
        sts = 4'h0; step();
        checks++;
        if ({st, preq, np, nr} !== {3'd4, 1'b0, 5'd1, 5'd0}) begin
            errors++; $display("FAIL rt_wait state=%0d preq=%b np=%0d nr=%0d want 4/0/1/0", st, preq, np, nr);
        end
        sts = 4'hF; step();
        checks++;
        if ({st, send, np, nr} !== {3'd1, 1'b1, 5'd1, 5'd0}) begin
            errors++; $display("FAIL rt_back state=%0d send=%b np=%0d nr=%0d want 1/1/1/0", st, send, np, nr);
        end
    endtask

    task automatic test_reinit_threshold();
        pthr = 5'd1; lnk = 0; step();
        checks++;
        if (st !== 3'd3 || preq !== 1'b0) begin
            errors++; $display("FAIL ri_enter state=%0d preq=%b want 3/0", st, preq);
        end
        step();
        checks++;
        if ({st, lfail, phit, disc} !== {3'd5, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ri_abort state=%0d lf=%b hit=%b disc=%b want 5/1/1/1", st, lfail, phit, disc);
        end
        clr = 1; step();
        checks++;
        if ({st, lfail, phit, rhit} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ri_clr state=%0d lf=%b phit=%b rhit=%b want 5/1/0/0", st, lfail, phit, rhit);
        end
        lnk = 1; crc = 1; step(); step();
        checks++;
        if (st !== 3'd5 || lfail !== 1'b1) begin
            errors++; $display("FAIL ri_terminal state=%0d lf=%b want 5/1", st, lfail);
        end
        do_reset();
        checks++;
        if (st !== 3'd0 || lfail !== 1'b0) begin
            errors++; $display("FAIL ri_reset state=%0d lf=%b want 0/0", st, lfail);
        end
    endtask

    task automatic test_link_down();
        rthr = 5'd3; pthr = 5'd3; tmax = 13'd0; lnk = 1; sts = 4'hF;
        crc = 1; step();
        sent = 1; step();
        lnk = 0; ack = 1; step();
        checks++;
        if ({st, nr, preq} !== {3'd3, 5'd1, 1'b1}) begin
            errors++; $display("FAIL ld_prio state=%0d nr=%0d preq=%b want 3/1/1", st, nr, preq);
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1;
        #1;
        checks++;
        if ({st, preq, disc, nr, np} !== 16'd0) begin
            errors++; $display("FAIL async_rst state=%0d preq=%b disc=%b nr=%0d np=%0d want 0", st, preq, disc, nr, np);
        end
        model_reset();
        #1 rst = 0; lnk = 1;
    endtask

    task automatic test_random();
        logic [18:0] act, exp;
        int nerr = 0;
        for (int c = 0; c < 3000 && nerr < 20; c++) begin
            if (c % 250 == 0) begin
                rthr = RW'($urandom_range(0, 4));
                pthr = RW'($urandom_range(0, 3));
                tmax = TW'($urandom_range(0, 5));
            end
            if ((m_state == 5 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
                do_reset();
            lnk   = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2: sts = 4'h0;
                3, 4, 5, 6, 7: sts = 4'hF;
                default: sts = 4'($urandom_range(1, 14));
            endcase
            crc   = ($urandom_range(0, 9) == 0);
            ack   = ($urandom_range(0, 9) == 0);
            sent  = ($urandom_range(0, 2) == 0);
            ftick = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 19) == 0);
            step();
            act = {st, send, preq, disc, lfail, rhit, phit, nr, np};
            exp = {3'(m_state), m_send, m_preq, m_state != 0, m_state == 5, m_rhit, m_phit,
                   RW'(m_nr), RW'(m_np)};
            checks++;
            if (act !== exp) begin
                errors++; nerr++;
                $display("FAIL rand_cycle%0d got=%h want=%h", c, act, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc_recovery();
        test_timeout();
        test_retry_threshold();
        test_reinit_threshold();
        test_link_down();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/llr_retry_seq_ctrl.md
# llr_retry_seq_ctrl

Link-layer retry sequencer for the CXL link-layer retry (LLR) path. It owns the local retry state machine (NORMAL / LLRREQ / LOCAL_IDLE / PHY_REINIT / PHY_WAIT / ABORT) and tells the control-flit packer when to emit a RETRY.Req. It tells the physical layer when to reinitialise and tells the unpacker when to discard received flits. It also maintains the NUM_RETRY and NUM_PHY_REINIT counters, the retry timeout and the threshold/link-failure status reported to the register file.

## Interface
- RETRY_W, 5, width of retry / reinit counters and thresholds
- TO_W, 13, width of retry timeout counter and limit

- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_pl_lnk_up  in  1  PHY link up
- i_pl_state_sts  in  4  PHY state; 4'h0 = reinit in progress, 4'hF = active
- i_rx_crc_err  in  1  pulse: unpacker saw a flit with bad CRC
- i_rx_retry_ack  in  1  pulse: RETRY.Ack received
- i_req_sent  in  1  pulse: packer transmitted the RETRY.Req
- i_flit_tick  in  1  pulse: one flit transfer elapsed (timeout time base)
- i_retry_threshold  in  RETRY_W  MAX_NUM_RETRY
- i_reinit_threshold  in  RETRY_W  MAX_NUM_PHY_REINIT
- i_timeout_max  in  TO_W  timeout in flit ticks; 0 disables timeout
- i_sts_clr  in  1  pulse: clear sticky threshold-hit flags
- o_send_req_seq  out  1  request packer to send RETRY.Req
- o_phy_reinit_req  out  1  request PHY reinitialisation
- o_discard_rx  out  1  unpacker must discard received flits
- o_link_failure  out  1  link failure, sticky until reset
- o_retry_threshold_hit  out  1  sticky
- o_reinit_threshold_hit  out  1  sticky
- o_num_retry  out  RETRY_W  NUM_RETRY
- o_num_phy_reinit  out  RETRY_W  NUM_PHY_REINIT
- o_state  out  3  NORMAL=0, LLRREQ=1, LOCAL_IDLE=2, PHY_REINIT=3, PHY_WAIT=4, ABORT=5

## Operation
- **Link-down override:** !i_pl_lnk_up in NORMAL, LLRREQ or LOCAL_IDLE goes to PHY_REINIT. It has priority over every other event in those states.
- **NORMAL:**
  - i_rx_crc_err goes to LLRREQ.
  - i_rx_retry_ack and i_req_sent are ignored.
- **LLRREQ:**
  - If o_num_retry >= i_retry_threshold: go to PHY_REINIT and set o_retry_threshold_hit. o_send_req_seq stays 0.
  - Otherwise o_send_req_seq=1. On i_req_sent: num_retry+1 (saturating), timeout counter cleared, go to LOCAL_IDLE.
- **LOCAL_IDLE:**
  - The timeout counter increments on i_flit_tick and saturates.
  - i_rx_retry_ack: go to NORMAL and clear num_retry and num_phy_reinit.
  - Otherwise, if i_timeout_max != 0 and i_flit_tick and count == i_timeout_max-1: go to LLRREQ.
  - Ack has priority over a same-cycle timeout.
- **PHY_REINIT:**
  - If num_phy_reinit >= i_reinit_threshold: go to ABORT and set o_reinit_threshold_hit.
  - Otherwise o_phy_reinit_req=1 until i_pl_state_sts == 4'h0, then go to PHY_WAIT.
  - On the PHY_WAIT transition: num_phy_reinit+1 (saturating) and num_retry cleared.
- **PHY_WAIT:** i_pl_lnk_up && i_pl_state_sts == 4'hF goes to LLRREQ.
- **ABORT:** terminal. o_link_failure=1 and o_discard_rx=1; leaves only by reset.
- **o_discard_rx:** 1 in every state except NORMAL.
- **i_rx_crc_err:** ignored outside NORMAL.
- **Sticky flags:** cleared by i_sts_clr. A same-cycle set wins over clear.

## Timing
- All state, counters and flags are registered. Outputs are decoded from registers only, with no input-to-output combinational path.
- Reset values: state NORMAL, all outputs 0, counters 0, o_state 3'd0.
- i_rx_crc_err at cycle N gives o_state=LLRREQ and o_send_req_seq=1 at N+1.
- i_req_sent at cycle N gives o_send_req_seq=0 and o_num_retry updated at N+1.
- **Handshake:** o_send_req_seq is held high until i_req_sent. i_req_sent while o_send_req_seq=0 is ignored.
- A threshold comparison uses the registered counter value, so the counter equals the threshold for exactly one LLRREQ cycle before PHY_REINIT.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronously). This includes an active o_phy_reinit_req.

## Test plan
- **Single CRC error recovery:** threshold 3, timeout 8. i_rx_crc_err, then i_req_sent 2 cycles later, then i_rx_retry_ack 3 cycles later. Expect states 0→1→2→0, o_num_retry 0→1→0, o_discard_rx high from N+1 until the ack cycle+1.
- **Timeout:** timeout_max=4, no ack, i_flit_tick every cycle. Expect re-entry to LLRREQ on the 4th tick and o_num_retry=2 after the second i_req_sent. With a same-cycle ack and 4th tick, expect NORMAL.
- **Retry threshold:** i_retry_threshold=2, repeated timeouts. Expect PHY_REINIT after 2 requests, o_retry_threshold_hit=1, o_phy_reinit_req=1 until i_pl_state_sts=0, then PHY_WAIT. Driving sts=F with link up gives LLRREQ with o_num_phy_reinit=1 and o_num_retry=0.
- **Reinit threshold:** i_reinit_threshold=1, force a second PHY_REINIT. Expect ABORT, o_link_failure=1 and o_reinit_threshold_hit=1. i_sts_clr clears the hit flag only; o_link_failure persists until i_rst.
- **Link down:** drop i_pl_lnk_up in LOCAL_IDLE in the same cycle as i_rx_retry_ack. Expect PHY_REINIT, not NORMAL.
- **Async reset:** assert i_rst while in PHY_REINIT. Expect o_phy_reinit_req, counters and o_state=0 before the next clock edge.
